// File: rtl/motor_pkg.sv
// Shared motor-model definitions: quadrature encodings, direction constants,
// accumulator period derivation and quadrature sequencing helper.
package motor_pkg;

   // Encoded directly as {a,b} so the state register drives the pins.
   typedef enum logic [1:0] {
      QUAD_S0 = 2'b00,
      QUAD_S1 = 2'b10,
      QUAD_S2 = 2'b11,
      QUAD_S3 = 2'b01
   } quad_e;

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   localparam longint SEC_PER_MIN = 64'sd60;

   function automatic longint period_of(input longint clk_hz);
      return clk_hz * SEC_PER_MIN;
   endfunction

   function automatic quad_e quad_next(input quad_e s, input logic d);
      quad_e n;
      case (s)
         QUAD_S0: n = (d == DIR_CW) ? QUAD_S1 : QUAD_S3;
         QUAD_S1: n = (d == DIR_CW) ? QUAD_S2 : QUAD_S0;
         QUAD_S2: n = (d == DIR_CW) ? QUAD_S3 : QUAD_S1;
         QUAD_S3: n = (d == DIR_CW) ? QUAD_S0 : QUAD_S2;
         default: n = QUAD_S0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/quad_stepper.sv
// Quadrature waveform sequencer: a/b state, position counter and, with
// RPM_TO_ENCODER_INDEX_EN defined, the once-per-revolution index output z.
module quad_stepper
   import motor_pkg::*;
#(
   parameter int EDGES_PER_REV = 48
) (
   input  logic        cclk,
   input  logic        rst,
   input  logic        adv,
   input  logic        dir,
   output logic        a,
   output logic        b,
   output logic [15:0] pos
`ifdef RPM_TO_ENCODER_INDEX_EN
   ,
   output logic        z
`endif
);

   localparam logic [15:0] POS_MAX = 16'(4 * EDGES_PER_REV - 1);

   quad_e       state_q, state_d;
   logic [15:0] pos_q, pos_d;

   // Next state and position for one advance in the sampled direction.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      if (adv) begin
         state_d = quad_next(state_q, dir);
         if (dir == DIR_CW) begin
            pos_d = (pos_q == POS_MAX) ? 16'd0 : pos_q + 16'd1;
         end else begin
            pos_d = (pos_q == 16'd0) ? POS_MAX : pos_q - 16'd1;
         end
      end else begin
         state_d = state_q;
         pos_d   = pos_q;
      end
   end

   // Quadrature state and position registers.
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         state_q <= QUAD_S0;
         pos_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
      end
   end

   assign a   = state_q[1];
   assign b   = state_q[0];
   assign pos = pos_q;

`ifdef RPM_TO_ENCODER_INDEX_EN
   logic z_q;

   // Index follows the next position so it moves with the a/b edge.
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         z_q <= 1'b0;
      end else begin
         z_q <= (pos_d == 16'd0);
      end
   end

   assign z = z_q;
`endif

endmodule

// File: rtl/rpm_to_encoder.sv
// Quadrature encoder emulator: rpm*gr rate pipeline feeding an exact-rate
// phase accumulator. Optional index output z via RPM_TO_ENCODER_INDEX_EN.
module rpm_to_encoder
   import motor_pkg::*;
#(
   parameter longint CLK_HZ        = 1000000,
   parameter int     EDGES_PER_REV = 48,
   parameter int     ACC_W         = 40
) (
   input  logic        cclk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  rpm,
   input  logic [7:0]  gr,
   input  logic        dir,
   output logic        a,
   output logic        b,
   output logic [15:0] pos
`ifdef RPM_TO_ENCODER_INDEX_EN
   ,
   output logic        z
`endif
);

   localparam longint PERIOD = period_of(CLK_HZ);
   localparam longint QSTEPS = longint'(4 * EDGES_PER_REV);
   localparam logic [ACC_W-1:0] PERIOD_W = ACC_W'(PERIOD);
   localparam logic [ACC_W-1:0] QSTEPS_W = ACC_W'(QSTEPS);

   // The maximum step must stay below PERIOD so one cycle never holds two advances.
   if (64'sd255 * 64'sd255 * QSTEPS >= PERIOD) begin : g_rate_chk
      $error("rpm_to_encoder: 255*255*4*EDGES_PER_REV must be below CLK_HZ*60");
   end
   if ((2 * PERIOD) > ((64'sd1 <<< ACC_W) - 64'sd1)) begin : g_width_chk
      $error("rpm_to_encoder: ACC_W too narrow for 2*PERIOD");
   end

   logic [15:0]      prod_q, prod_d;
   logic [ACC_W-1:0] step_q, step_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] sum_s;
   logic             adv_s;

   // Rate pipeline and accumulator next-state; acc stays below PERIOD.
   always_comb begin
      prod_d = {8'd0, rpm} * {8'd0, gr};
      step_d = ACC_W'(prod_q) * QSTEPS_W;
      sum_s  = acc_q + step_q;
      acc_d  = acc_q;
      adv_s  = 1'b0;
      if (en) begin
         if (sum_s >= PERIOD_W) begin
            acc_d = sum_s - PERIOD_W;
            adv_s = 1'b1;
         end else begin
            acc_d = sum_s;
            adv_s = 1'b0;
         end
      end else begin
         acc_d = {ACC_W{1'b0}};
         adv_s = 1'b0;
      end
   end

   // Step pipeline and phase accumulator registers.
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         prod_q <= 16'd0;
         step_q <= {ACC_W{1'b0}};
         acc_q  <= {ACC_W{1'b0}};
      end else begin
         prod_q <= prod_d;
         step_q <= step_d;
         acc_q  <= acc_d;
      end
   end

   quad_stepper #(
      .EDGES_PER_REV (EDGES_PER_REV)
   ) u_stepper (
      .cclk (cclk),
      .rst  (rst),
      .adv  (adv_s),
      .dir  (dir),
      .a    (a),
      .b    (b),
      .pos  (pos)
`ifdef RPM_TO_ENCODER_INDEX_EN
      ,
      .z    (z)
`endif
   );

endmodule

// File: tb/tb_rpm_to_encoder.sv
// Scoreboard bench for rpm_to_encoder: expected advances (state, position,
// cycle) are queued by the stimulus and popped by a monitor on each output change.
module tb_rpm_to_encoder;
   import motor_pkg::*;

   localparam int     Q = 192;
   localparam longint P = 64'sd60000000;

   logic        cclk = 1'b0;
   logic        rst;
   logic        en, dir;
   logic [7:0]  rpm, gr;
   logic        a, b;
   logic [15:0] pos;
`ifdef RPM_TO_ENCODER_INDEX_EN
   logic        z;
`endif

   rpm_to_encoder #(.CLK_HZ(1000000), .EDGES_PER_REV(48), .ACC_W(40)) dut (
      .cclk (cclk),
      .rst  (rst),
      .en   (en),
      .rpm  (rpm),
      .gr   (gr),
      .dir  (dir),
      .a    (a),
      .b    (b),
      .pos  (pos)
`ifdef RPM_TO_ENCODER_INDEX_EN
      ,
      .z    (z)
`endif
   );

   always #5 cclk = ~cclk;

   int cyc = 0;
   always @(posedge cclk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0] ab;
      int         pos;
      int         cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          m_pos  = 0;
   int          rises  = 0;
   logic [17:0] prev   = 18'd0;
   exp_t        e_m;

   function automatic logic [1:0] ab_of(input int p);
      case (p % 4)
         0:       return 2'b00;
         1:       return 2'b10;
         2:       return 2'b11;
         default: return 2'b01;
      endcase
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", nm, act, exp);
      end
   endtask

   // n-th advance after acc starts from 0 lands ceil(n*P/step) cycles after base.
   task automatic push_run(input longint step, input int base, input int n_first,
                           input int n_last, input logic d);
      exp_t e;
      for (int n = n_first; n <= n_last; n++) begin
         m_pos  = (d == DIR_CW) ? (m_pos + 1) % Q : (m_pos + Q - 1) % Q;
         e.ab   = ab_of(m_pos);
         e.pos  = m_pos;
         e.cyc  = base + int'((longint'(n) * P + step - 64'sd1) / step);
         sb.push_back(e);
      end
   endtask

   task automatic wait_drain(input int limit);
      int k;
      k = 0;
      while (sb.size() != 0 && k < limit) begin
         @(negedge cclk);
         #1;
         k++;
      end
      chk("drain", longint'(sb.size()), 0);
      sb.delete();
   endtask

   // Monitor: every output change must be the next queued advance.
   always @(negedge cclk) begin
      if (rst) begin
         prev = 18'd0;
      end else begin
`ifdef RPM_TO_ENCODER_INDEX_EN
         checks++;
         if (z !== (pos == 16'd0)) begin
            errors++;
            $display("FAIL index z=%0b pos=%0d cyc=%0d", z, pos, cyc);
         end
`endif
         if ({a, b, pos} !== prev) begin
            checks++;
            if ($countones({a, b} ^ prev[17:16]) != 1) begin
               errors++;
               $display("FAIL single_bit ab %b -> %b cyc=%0d", prev[17:16], {a, b}, cyc);
            end
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_adv ab=%b pos=%0d cyc=%0d", {a, b}, pos, cyc);
            end else begin
               e_m = sb.pop_front();
               if ({a, b} !== e_m.ab || pos !== 16'(e_m.pos) || cyc != e_m.cyc) begin
                  errors++;
                  $display("FAIL adv actual ab=%b pos=%0d cyc=%0d expected ab=%b pos=%0d cyc=%0d",
                           {a, b}, pos, cyc, e_m.ab, e_m.pos, e_m.cyc);
               end
            end
            if (a && !prev[17]) rises++;
            prev = {a, b, pos};
         end
      end
   end

   int t, c0, r0;

   initial begin
      rst = 1'b1; en = 1'b0; dir = DIR_CW; rpm = 8'd0; gr = 8'd0;
      repeat (3) @(negedge cclk);
      #1;
      chk("rst_a", a, 0);
      chk("rst_b", b, 0);
      chk("rst_pos", pos, 0);
`ifdef RPM_TO_ENCODER_INDEX_EN
      chk("rst_z", z, 0);
`endif
      #1 rst = 1'b0;

      // Zero rate: enabled but rpm=0, nothing may move.
      @(negedge cclk);
      en = 1'b1; gr = 8'd255; rpm = 8'd0;
      repeat (2000) @(negedge cclk);
      #1;
      chk("zero_pos", pos, 0);
      chk("zero_ab", {a, b}, 0);

      // Latency and max rate: rpm 0->255 at cycle T, step 12484800.
      @(negedge cclk);
      t = cyc;
      rpm = 8'd255;
      push_run(64'sd12484800, t + 2, 1, 20, DIR_CW);
      wait_drain(300);
      en = 1'b0;

      // Freeze: en=0 holds outputs.
      repeat (50) @(negedge cclk);
      #1;
      chk("frz_pos", pos, 20);
      chk("frz_ab", {a, b}, 2'b00);

      // Exact rate: step 12000000 gives one advance every 5 cycles.
      rpm = 8'd250; gr = 8'd250; dir = DIR_CW;
      repeat (3) @(negedge cclk);
      c0 = cyc;
      push_run(64'sd12000000, c0, 1, 1920, DIR_CW);
      r0 = rises;
      en = 1'b1;
      wait_drain(12000);
      en = 1'b0;
      chk("rate_rises", rises - r0, 480);
      chk("rate_pos", pos, 20);

      // Async reset mid-run at rpm=100, gr=10.
      rpm = 8'd100; gr = 8'd10;
      repeat (3) @(negedge cclk);
      c0 = cyc;
      push_run(64'sd192000, c0, 1, 3, DIR_CW);
      en = 1'b1;
      wait_drain(2000);
      chk("pre_rst_pos", pos, 23);
      @(negedge cclk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ab", {a, b}, 0);
      chk("mid_rst_pos", pos, 0);
      m_pos = 0;
      repeat (2) @(negedge cclk);
      en = 1'b0;
      #2 rst = 1'b0;

      // CCW from 00 (first advance 0->191, ab=01), then reverse mid-run.
      @(negedge cclk);
      dir = DIR_CCW;
      repeat (3) @(negedge cclk);
      c0 = cyc;
      push_run(64'sd192000, c0, 1, 8, DIR_CCW);
      en = 1'b1;
      wait_drain(4000);
      chk("ccw_pos", pos, 184);
      dir = DIR_CW;
      push_run(64'sd192000, c0, 9, 12, DIR_CW);
      wait_drain(2000);
      en = 1'b0;
      chk("flip_pos", pos, 188);
      chk("flip_ab", {a, b}, 2'b00);

      repeat (5) @(negedge cclk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
